// File: rtl/ifm_pad_writer.sv
// Zero-padding IFM writer: walks the padded feature map (channel-word, x, y) and emits one buffer write per step.
// Optional `PAD_ERR_CHECK_EN adds a sticky protocol error flag (err).
module ifm_pad_writer #(
  parameter int unsigned PE      = 16,
  parameter int unsigned DIM_W   = 10,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MAX_PAD = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DIM_W-1:0]    cfg_c,
  input  logic [DIM_W-1:0]    cfg_w,
  input  logic [DIM_W-1:0]    cfg_h,
  input  logic [1:0]          cfg_pad,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PE*8-1:0]     in_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [PE*8-1:0]     wr_data,
  output logic                row_done,
  output logic                busy,
  output logic                done
`ifdef PAD_ERR_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int unsigned PE_SHIFT = $clog2(PE);
  localparam int unsigned CNT_W    = DIM_W + 2;
  localparam int unsigned DATA_W   = PE * 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  // latched frame geometry (all limits stored as last-index or exclusive bound)
  logic [CNT_W-1:0]  cw_m1, wp_m1, hp_m1;
  logic [CNT_W-1:0]  pad_lo, x_hi, y_hi;
  logic [CNT_W-1:0]  c_i, x, y;
  logic [ADDR_W-1:0] addr;

  logic [DIM_W-1:0]  cw_raw;
  logic [CNT_W-1:0]  pad_cl;
  logic              data_pos_c, step_c, last_c_c, last_x_c;
  logic              row_end_c, frame_end_c, start_ok_c, geom_empty_c;

  logic              wr_en_nxt, row_done_nxt, busy_nxt, done_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;

  assign cw_raw       = cfg_c >> PE_SHIFT;
  assign pad_cl       = (CNT_W'(cfg_pad) > CNT_W'(MAX_PAD)) ? CNT_W'(MAX_PAD) : CNT_W'(cfg_pad);
  assign geom_empty_c = (cfg_w == '0) || (cfg_h == '0);
  assign start_ok_c   = (state == S_IDLE) && start;

  assign data_pos_c  = (x >= pad_lo) && (x < x_hi) && (y >= pad_lo) && (y < y_hi);
  assign in_ready    = (state == S_RUN) && data_pos_c;
  assign step_c      = (state == S_RUN) && (!data_pos_c || in_valid);
  assign last_c_c    = (c_i == cw_m1);
  assign last_x_c    = (x == wp_m1);
  assign row_end_c   = step_c && last_c_c && last_x_c;
  assign frame_end_c = row_end_c && (y == hp_m1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = geom_empty_c ? S_DONE : S_RUN;
      S_RUN:   if (frame_end_c) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // output logic; busy stays up through the cycle that carries done
  always_comb begin
    wr_en_nxt    = step_c;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    row_done_nxt = row_end_c;
    busy_nxt     = (state_nxt != S_IDLE) || (state == S_DONE);
    done_nxt     = (state == S_DONE);
    if (step_c) begin
      wr_addr_nxt = addr;
      wr_data_nxt = data_pos_c ? in_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      row_done <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      wr_en    <= wr_en_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      row_done <= row_done_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // geometry latch, raster counters and linear address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_m1  <= '0;
      wp_m1  <= '0;
      hp_m1  <= '0;
      pad_lo <= '0;
      x_hi   <= '0;
      y_hi   <= '0;
      c_i    <= '0;
      x      <= '0;
      y      <= '0;
      addr   <= '0;
    end else if (start_ok_c) begin
      cw_m1  <= (cw_raw == '0) ? '0 : CNT_W'(cw_raw) - CNT_W'(1);
      wp_m1  <= CNT_W'(cfg_w) + CNT_W'(pad_cl << 1) - CNT_W'(1);
      hp_m1  <= CNT_W'(cfg_h) + CNT_W'(pad_cl << 1) - CNT_W'(1);
      pad_lo <= pad_cl;
      x_hi   <= pad_cl + CNT_W'(cfg_w);
      y_hi   <= pad_cl + CNT_W'(cfg_h);
      c_i    <= '0;
      x      <= '0;
      y      <= '0;
      addr   <= cfg_base;
    end else if (step_c) begin
      addr <= addr + ADDR_W'(1);
      if (last_c_c) begin
        c_i <= '0;
        if (last_x_c) begin
          x <= '0;
          y <= y + CNT_W'(1);
        end else begin
          x <= x + CNT_W'(1);
        end
      end else begin
        c_i <= c_i + CNT_W'(1);
      end
    end
  end

`ifdef PAD_ERR_CHECK_EN
  // sticky: start while a frame is active, or input offered outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err <= 1'b0;
    else if (start_ok_c) err <= 1'b0;
    else if ((start && (state != S_IDLE)) || (in_valid && (state != S_RUN)))
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ifm_pad_writer.sv
// Directed self-checking bench for ifm_pad_writer (instance built with MAX_PAD=2).
// Covers padded/unpadded frames, backpressure, degenerate and clamped geometry, mid-frame reset.
module tb_ifm_pad_writer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   cfg_c = '0, cfg_w = '0, cfg_h = '0;
  logic [1:0]   cfg_pad = '0;
  logic [31:0]  cfg_base = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         wr_en;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         row_done, busy, done;
`ifdef PAD_ERR_CHECK_EN
  logic         err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ifm_pad_writer #(.PE(16), .DIM_W(10), .ADDR_W(32), .MAX_PAD(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_c    (cfg_c),
    .cfg_w    (cfg_w),
    .cfg_h    (cfg_h),
    .cfg_pad  (cfg_pad),
    .cfg_base (cfg_base),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .row_done (row_done),
    .busy     (busy),
    .done     (done)
`ifdef PAD_ERR_CHECK_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int k);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(k);
    return {w, w, w, w};
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, " wr_en"},    128'(wr_en),    128'(0));
    check({tag, " wr_addr"},  128'(wr_addr),  128'(0));
    check({tag, " wr_data"},  wr_data,        128'(0));
    check({tag, " row_done"}, 128'(row_done), 128'(0));
    check({tag, " busy"},     128'(busy),     128'(0));
    check({tag, " done"},     128'(done),     128'(0));
    check({tag, " in_ready"}, 128'(in_ready), 128'(0));
  endtask

  // vmode 0: in_valid held high; vmode 1: toggles 1,0,1,0
  task automatic run_frame(input string name, input logic [9:0] c, input logic [9:0] w,
                           input logic [9:0] h, input logic [1:0] pad, input logic [31:0] base,
                           input int vmode, input int exp_done, input int inj_rel, input int rst_after);
    logic [31:0]  ea[$];
    logic [127:0] ed[$];
    logic         er[$];
    logic         ep[$];
    int pc, cw, wp, hp, nd, widx, beats, rel, first_rel, done_rel, last_wr_rel, gaps;
    logic dp;

    pc = (int'(pad) > 2) ? 2 : int'(pad);
    cw = int'(c) >> 4;
    if (cw == 0) cw = 1;
    wp = int'(w) + 2 * pc;
    hp = int'(h) + 2 * pc;
    nd = 0;
    if (w != 0 && h != 0) begin
      for (int yy = 0; yy < hp; yy++)
        for (int xx = 0; xx < wp; xx++)
          for (int ci = 0; ci < cw; ci++) begin
            dp = (xx >= pc) && (xx < pc + int'(w)) && (yy >= pc) && (yy < pc + int'(h));
            ea.push_back(base + 32'(ea.size()));
            ed.push_back(dp ? pat(nd) : 128'(0));
            ep.push_back(!dp);
            er.push_back((ci == cw - 1) && (xx == wp - 1));
            if (dp) nd++;
          end
    end

    @(negedge clk);
    cfg_c = c; cfg_w = w; cfg_h = h; cfg_pad = pad; cfg_base = base;
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cfg_c = 10'h3ff; cfg_w = 10'd5; cfg_h = 10'd1; cfg_pad = 2'd0; cfg_base = 32'hDEAD0000;

    rel = 0; widx = 0; beats = 0; first_rel = -1; done_rel = -1; last_wr_rel = -1; gaps = 0;
    check({name, " busy_start"}, 128'(busy), 128'(1));
`ifdef PAD_ERR_CHECK_EN
    check({name, " err_cleared"}, 128'(err), 128'(0));
`endif
    while (done_rel < 0 && rel < 1000) begin
      if (wr_en) begin
        if (widx < ea.size()) begin
          check($sformatf("%s addr[%0d]", name, widx), 128'(wr_addr), 128'(ea[widx]));
          check($sformatf("%s data[%0d]", name, widx), wr_data, ed[widx]);
          check($sformatf("%s row_done[%0d]", name, widx), 128'(row_done), 128'(er[widx]));
          if (ep[widx] && last_wr_rel >= 0 && rel != last_wr_rel + 1) gaps++;
        end
        if (first_rel < 0) first_rel = rel;
        last_wr_rel = rel;
        widx++;
        if (rst_after > 0 && widx == rst_after) begin
          rst_n = 1'b0;
          in_valid = 1'b0;
          start = 1'b0;
          #1;
          check_outputs_zero({name, " midreset"});
`ifdef PAD_ERR_CHECK_EN
          check({name, " midreset err"}, 128'(err), 128'(0));
`endif
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
      if (done) begin
        done_rel = rel;
        check({name, " busy_at_done"}, 128'(busy), 128'(1));
      end
`ifdef PAD_ERR_CHECK_EN
      if (inj_rel >= 0 && rel == inj_rel + 1)
        check({name, " err_set"}, 128'(err), 128'(1));
`endif
      start    = (rel == inj_rel);
      in_valid = (beats < nd) && (vmode == 0 || (rel % 2) == 0);
      in_data  = pat(beats);
      if (in_valid && in_ready) beats++;
      if (done_rel < 0) begin
        @(negedge clk);
        rel++;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;

    check({name, " done_seen"}, 128'(done_rel >= 0), 128'(1));
    if (exp_done >= 0) check({name, " done_cycle"}, 128'(done_rel), 128'(exp_done));
    check({name, " n_writes"}, 128'(widx), 128'(ea.size()));
    check({name, " n_beats"}, 128'(beats), 128'(nd));
    check({name, " pad_gaps"}, 128'(gaps), 128'(0));
    if (ea.size() > 0) check({name, " first_write"}, 128'(first_rel), 128'(1));
`ifdef PAD_ERR_CHECK_EN
    if (inj_rel >= 0) check({name, " err_sticky"}, 128'(err), 128'(1));
`endif
    @(negedge clk);
    check({name, " busy_after"}, 128'(busy), 128'(0));
    check({name, " done_after"}, 128'(done), 128'(0));
  endtask

  initial begin
    #12;
    check_outputs_zero("reset");
`ifdef PAD_ERR_CHECK_EN
    check("reset err", 128'(err), 128'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_frame("padded",   10'd32, 10'd2, 10'd2, 2'd1, 32'h100, 0, 33, -1, 0);
    run_frame("nopad",    10'd32, 10'd2, 10'd2, 2'd0, 32'h100, 0, 9,  -1, 0);
    run_frame("backpres", 10'd32, 10'd2, 10'd2, 2'd1, 32'h100, 1, -1, 5,  0);
    run_frame("w_zero",   10'd32, 10'd0, 10'd2, 2'd1, 32'h100, 0, 1,  -1, 0);
    run_frame("pad3",     10'd32, 10'd2, 10'd2, 2'd3, 32'h200, 0, 73, -1, 0);
    run_frame("pad2",     10'd32, 10'd2, 10'd2, 2'd2, 32'h200, 0, 73, -1, 0);
    run_frame("narrow_c", 10'd8,  10'd3, 10'd1, 2'd1, 32'hFFFF_FFFE, 0, 16, -1, 0);
    run_frame("rst_mid",  10'd32, 10'd2, 10'd2, 2'd1, 32'h100, 0, 33, -1, 10);
    run_frame("replay",   10'd32, 10'd2, 10'd2, 2'd1, 32'h100, 0, 33, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
